// File: rtl/dilithium_field_sequencer.sv
// Walks the Dilithium operand fields for a keygen/sign/verify request and emits
// one (field, word-index) descriptor per bus word with valid/ready handshaking.
module dilithium_field_sequencer #(
  parameter int SEC_LEVEL    = 2,
  parameter int W            = 32,
  parameter int MSG_SIZE     = 26400,
  parameter int MSG_LEN_SIZE = $clog2(MSG_SIZE),
  parameter int IDX_W        = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [MSG_LEN_SIZE-1:0] msg_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              field_id,
  output logic [IDX_W-1:0]        word_idx,
  output logic                    field_last,
  output logic                    seq_last,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef logic [IDX_W:0] cnt_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [1:0] MODE_SIGN   = 2'b10;
  localparam logic [1:0] MODE_VERIFY = 2'b01;
  localparam logic [1:0] MODE_BAD    = 2'b11;

  localparam logic [3:0] F_MSG_LEN = 4'd0, F_MSG = 4'd1, F_SEED = 4'd2, F_S1 = 4'd3,
                         F_S2 = 4'd4, F_T0 = 4'd5, F_T1 = 4'd6, F_Z = 4'd7, F_H = 4'd8;

  localparam int S1_BITS = (SEC_LEVEL == 2) ? 3072  : (SEC_LEVEL == 3) ? 5120  : 5376;
  localparam int S2_BITS = (SEC_LEVEL == 2) ? 3072  : 6144;
  localparam int T1_BITS = (SEC_LEVEL == 2) ? 10240 : (SEC_LEVEL == 3) ? 15360 : 20480;
  localparam int T0_BITS = (SEC_LEVEL == 2) ? 13312 : (SEC_LEVEL == 3) ? 19968 : 26624;
  localparam int Z_BITS  = (SEC_LEVEL == 2) ? 18432 : (SEC_LEVEL == 3) ? 25600 : 35840;
  localparam int H_BITS  = (SEC_LEVEL == 2) ? 672   : (SEC_LEVEL == 3) ? 488   : 664;

  localparam cnt_t SEED_WORDS = cnt_t'((256 + W - 1) / W);
  localparam cnt_t S1_WORDS   = cnt_t'((S1_BITS + W - 1) / W);
  localparam cnt_t S2_WORDS   = cnt_t'((S2_BITS + W - 1) / W);
  localparam cnt_t T1_WORDS   = cnt_t'((T1_BITS + W - 1) / W);
  localparam cnt_t T0_WORDS   = cnt_t'((T0_BITS + W - 1) / W);
  localparam cnt_t Z_WORDS    = cnt_t'((Z_BITS + W - 1) / W);
  localparam cnt_t H_WORDS    = cnt_t'((H_BITS + W - 1) / W);

  function automatic cnt_t words_of(input logic [3:0] f, input cnt_t mw);
    case (f)
      F_MSG_LEN: words_of = cnt_t'(1);
      F_MSG:     words_of = mw;
      F_SEED:    words_of = SEED_WORDS;
      F_S1:      words_of = S1_WORDS;
      F_S2:      words_of = S2_WORDS;
      F_T0:      words_of = T0_WORDS;
      F_T1:      words_of = T1_WORDS;
      F_Z:       words_of = Z_WORDS;
      F_H:       words_of = H_WORDS;
      default:   words_of = '0;
    endcase
  endfunction

  // Slot -> field map per mode; unused slots fall back to SEED and are never reached.
  function automatic logic [3:0] field_at(input logic [1:0] m, input logic [2:0] s);
    field_at = F_SEED;
    if (m == MODE_SIGN) begin
      case (s)
        3'd0:    field_at = F_MSG_LEN;
        3'd1:    field_at = F_MSG;
        3'd5:    field_at = F_S1;
        3'd6:    field_at = F_S2;
        3'd7:    field_at = F_T0;
        default: field_at = F_SEED;
      endcase
    end else if (m == MODE_VERIFY) begin
      case (s)
        3'd0:    field_at = F_MSG_LEN;
        3'd1:    field_at = F_MSG;
        3'd3:    field_at = F_T1;
        3'd5:    field_at = F_Z;
        3'd6:    field_at = F_H;
        default: field_at = F_SEED;
      endcase
    end
  endfunction

  function automatic logic [2:0] last_slot(input logic [1:0] m);
    last_slot = (m == MODE_SIGN) ? 3'd7 : (m == MODE_VERIFY) ? 3'd6 : 3'd0;
  endfunction

  state_t     state;
  logic [1:0] mode_r;
  cnt_t       msg_words_r, cur_cnt;
  logic [2:0] slot;

  cnt_t       st_mw, st_cnt, adv_cnt;
  logic [3:0] st_field, adv_field;
  logic [2:0] adv_slot;
  logic       bad_req, idx_last;

  // Only MSG can be empty, so skipping at most one slot is enough.
  always_comb begin
    st_mw     = cnt_t'((32'(msg_len) + 32'(W - 1)) / 32'(W));
    st_field  = field_at(mode, 3'd0);
    st_cnt    = words_of(st_field, st_mw);
    adv_slot  = slot + 3'd1;
    if (words_of(field_at(mode_r, adv_slot), msg_words_r) == '0) adv_slot = slot + 3'd2;
    adv_field = field_at(mode_r, adv_slot);
    adv_cnt   = words_of(adv_field, msg_words_r);
    idx_last  = (({1'b0, word_idx} + cnt_t'(2)) == cur_cnt);
    bad_req   = (mode == MODE_BAD) || (32'(msg_len) > 32'(MSG_SIZE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_r      <= '0;
      msg_words_r <= '0;
      cur_cnt     <= '0;
      slot        <= '0;
      out_valid   <= 1'b0;
      field_id    <= '0;
      word_idx    <= '0;
      field_last  <= 1'b0;
      seq_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (bad_req) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            state       <= S_RUN;
            busy        <= 1'b1;
            out_valid   <= 1'b1;
            mode_r      <= mode;
            msg_words_r <= st_mw;
            slot        <= '0;
            field_id    <= st_field;
            cur_cnt     <= st_cnt;
            word_idx    <= '0;
            field_last  <= (st_cnt == cnt_t'(1));
            seq_last    <= (st_cnt == cnt_t'(1)) && (last_slot(mode) == 3'd0);
          end
        end
        S_RUN: if (out_valid && out_ready) begin
          if (seq_last) begin
            state      <= S_DONE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            field_id   <= '0;
            word_idx   <= '0;
            field_last <= 1'b0;
            seq_last   <= 1'b0;
          end else if (field_last) begin
            slot       <= adv_slot;
            field_id   <= adv_field;
            cur_cnt    <= adv_cnt;
            word_idx   <= '0;
            field_last <= (adv_cnt == cnt_t'(1));
            seq_last   <= (adv_cnt == cnt_t'(1)) && (adv_slot == last_slot(mode_r));
          end else begin
            word_idx   <= word_idx + IDX_W'(1);
            field_last <= idx_last;
            seq_last   <= idx_last && (slot == last_slot(mode_r));
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dilithium_field_sequencer.sv
// Bench for dilithium_field_sequencer: L2/W32 and L5/W64 instances share stimulus
// and are each compared against a field-list model of the expected beat stream.
module tb_dilithium_field_sequencer;
  localparam int MLS = $clog2(26400);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [1:0] mode = '0;
  logic [MLS-1:0] msg_len = '0;
  logic [1:0] ov, fl, sl, bz, dn, er;
  logic [1:0][3:0] fid;
  logic [1:0][10:0] widx;

  dilithium_field_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .msg_len(msg_len),
    .out_valid(ov[0]), .out_ready(out_ready), .field_id(fid[0]), .word_idx(widx[0]),
    .field_last(fl[0]), .seq_last(sl[0]), .busy(bz[0]), .done(dn[0]), .error(er[0]));

  dilithium_field_sequencer #(.SEC_LEVEL(5), .W(64)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .msg_len(msg_len),
    .out_valid(ov[1]), .out_ready(out_ready), .field_id(fid[1]), .word_idx(widx[1]),
    .field_last(fl[1]), .seq_last(sl[1]), .busy(bz[1]), .done(dn[1]), .error(er[1]));

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] f; logic [10:0] idx; logic fl; logic sl;} beat_t;
  typedef struct {logic [1:0] m; int len; bit err; int n0; int n1; logic [3:0] first;} vec_t;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  beat_t got0[$], got1[$], exp0[$], exp1[$];
  int done_cnt[2], err_cnt[2], done_cyc[2], err_cyc[2];
  bit valid_seen[2], busy_seen[2], prev_stall[2];
  beat_t prev_d[2];
  bit rnd_ready = 1'b0, spam = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: expand the mode's field list into beats using the size table.
  function automatic int fbits(input int lvl, input int f);
    int li;
    int s1[3], s2[3], t0[3], t1[3], z[3], h[3];
    li = (lvl == 2) ? 0 : (lvl == 3) ? 1 : 2;
    s1 = '{3072, 5120, 5376};    s2 = '{3072, 6144, 6144};
    t1 = '{10240, 15360, 20480}; t0 = '{13312, 19968, 26624};
    z  = '{18432, 25600, 35840}; h  = '{672, 488, 664};
    case (f)
      2: return 256;
      3: return s1[li];
      4: return s2[li];
      5: return t0[li];
      6: return t1[li];
      7: return z[li];
      8: return h[li];
      default: return 0;
    endcase
  endfunction

  task automatic build(input int inst, input int lvl, input int w, input logic [1:0] m, input int len);
    beat_t lq[$];
    int fl_list[$];
    int sf[8], vf[7], n;
    sf = '{0, 1, 2, 2, 2, 3, 4, 5};
    vf = '{0, 1, 2, 6, 2, 7, 8};
    if (m == 2'b00) fl_list.push_back(2);
    else if (m == 2'b10) foreach (sf[k]) fl_list.push_back(sf[k]);
    else foreach (vf[k]) fl_list.push_back(vf[k]);
    foreach (fl_list[k]) begin
      if (fl_list[k] == 0) n = 1;
      else if (fl_list[k] == 1) n = (len + w - 1) / w;
      else n = (fbits(lvl, fl_list[k]) + w - 1) / w;
      for (int j = 0; j < n; j++)
        lq.push_back('{f: 4'(fl_list[k]), idx: 11'(j), fl: (j == n - 1), sl: 1'b0});
    end
    if (lq.size() > 0) lq[lq.size() - 1].sl = 1'b1;
    if (inst == 0) exp0 = lq; else exp1 = lq;
  endtask

  task automatic clear_mon();
    got0.delete(); got1.delete();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; err_cnt[i] = 0; done_cyc[i] = -1; err_cyc[i] = -1;
      valid_seen[i] = 0; busy_seen[i] = 0; prev_stall[i] = 0;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Input driver: random backpressure and ignored start pulses while both busy.
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (spam) begin
      start = (bz == 2'b11) ? ($urandom_range(0, 7) == 0) : 1'b0;
      mode = 2'($urandom_range(0, 3));
      msg_len = MLS'($urandom_range(0, 32767));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall[0] = 0; prev_stall[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        beat_t d;
        d = {fid[i], widx[i], fl[i], sl[i]};
        if (prev_stall[i]) chk($sformatf("stall_hold%0d", i), {ov[i], d}, {1'b1, prev_d[i]});
        if (ov[i] && out_ready) begin
          if (i == 0) got0.push_back(d); else got1.push_back(d);
        end
        prev_stall[i] = ov[i] && !out_ready;
        prev_d[i] = d;
        if (ov[i]) valid_seen[i] = 1;
        if (bz[i]) busy_seen[i] = 1;
        if (dn[i]) begin
          if (done_cnt[i] == 0) done_cyc[i] = cyc;
          done_cnt[i]++;
          chk($sformatf("done_idle%0d", i), {bz[i], ov[i]}, 2'b00);
        end
        if (er[i]) begin
          if (err_cnt[i] == 0) err_cyc[i] = cyc;
          err_cnt[i]++;
        end
      end
    end
  end

  task automatic run(input logic [1:0] m, input int len, input bit rnd, output int s_cyc);
    @(posedge clk); #1;
    clear_mon();
    start = 1'b1; mode = m; msg_len = MLS'(len); rnd_ready = rnd;
    @(posedge clk); #1;
    s_cyc = cyc; start = 1'b0; spam = rnd;
  endtask

  task automatic wait_end(input bit want_err, input int limit);
    int k = 0;
    while (k < limit && !(want_err ? (err_cnt[0] > 0 && err_cnt[1] > 0)
                                   : (done_cnt[0] > 0 && done_cnt[1] > 0))) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_bound", 32'(k < limit), 32'd1);
    spam = 1'b0; rnd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_run(input int s_cyc, input bit timed);
    for (int i = 0; i < 2; i++) begin
      beat_t g[$], e[$];
      g = (i == 0) ? got0 : got1;
      e = (i == 0) ? exp0 : exp1;
      chk($sformatf("n_beats%0d", i), g.size(), e.size());
      for (int j = 0; j < g.size() && j < e.size(); j++)
        chk($sformatf("beat%0d[%0d]", i, j), g[j], e[j]);
      chk($sformatf("done_pulses%0d", i), done_cnt[i], 1);
      chk($sformatf("err_pulses%0d", i), err_cnt[i], 0);
      if (timed) chk($sformatf("done_latency%0d", i), done_cyc[i] - s_cyc, e.size());
    end
  endtask

  vec_t vecs[7];
  int s;

  initial begin
    vecs[0] = '{2'b00, 0,     0, 8,    4,    4'd2};
    vecs[1] = '{2'b10, 100,   0, 637,  611,  4'd0};
    vecs[2] = '{2'b01, 0,     0, 934,  900,  4'd0};
    vecs[3] = '{2'b11, 50,    1, 0,    0,    4'd0};
    vecs[4] = '{2'b10, 26401, 1, 0,    0,    4'd0};
    vecs[5] = '{2'b10, 26400, 0, 1458, 1022, 4'd0};
    vecs[6] = '{2'b01, 1,     0, 935,  901,  4'd0};

    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs0", {ov[0], fid[0], widx[0], fl[0], sl[0], bz[0], dn[0], er[0]}, '0);
    chk("reset_outs1", {ov[1], fid[1], widx[1], fl[1], sl[1], bz[1], dn[1], er[1]}, '0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      build(0, 2, 32, vecs[v].m, vecs[v].len);
      build(1, 5, 64, vecs[v].m, vecs[v].len);
      run(vecs[v].m, vecs[v].len, 0, s);
      if (vecs[v].err) begin
        chk($sformatf("v%0d_err_now", v), {er, ov, bz}, 6'b110000);
        wait_end(1, 20);
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("v%0d_err_cnt%0d", v, i), err_cnt[i], 1);
          chk($sformatf("v%0d_err_lat%0d", v, i), err_cyc[i] - s, 0);
          chk($sformatf("v%0d_err_quiet%0d", v, i), {valid_seen[i], busy_seen[i], 8'(done_cnt[i])}, '0);
        end
      end else begin
        for (int i = 0; i < 2; i++)
          chk($sformatf("v%0d_first%0d", v, i), {ov[i], bz[i], fid[i], widx[i]}, {2'b11, vecs[v].first, 11'd0});
        wait_end(0, 4000);
        chk($sformatf("v%0d_tbl_n0", v), got0.size(), vecs[v].n0);
        chk($sformatf("v%0d_tbl_n1", v), got1.size(), vecs[v].n1);
        check_run(s, 1);
      end
    end

    // Backpressure, ignored restarts and random modes/lengths.
    for (int r = 0; r < 6; r++) begin
      logic [1:0] m;
      int len;
      m = (r % 3 == 0) ? 2'b00 : (r % 3 == 1) ? 2'b10 : 2'b01;
      len = $urandom_range(0, 26400);
      if (r == 1) len = 100;
      build(0, 2, 32, m, len);
      build(1, 5, 64, m, len);
      run(m, len, 1, s);
      wait_end(0, 9000);
      check_run(s, 0);
    end

    // Asynchronous reset in the middle of sign's T0 field, then a clean keygen.
    run(2'b10, 100, 0, s);
    for (int k = 0; k < 2000 && fid[0] != 4'd5; k++) @(negedge clk);
    chk("reach_t0", fid[0], 4'd5);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst0", {ov[0], fid[0], widx[0], fl[0], sl[0], bz[0], dn[0], er[0]}, '0);
    chk("mid_rst1", {ov[1], fid[1], widx[1], fl[1], sl[1], bz[1], dn[1], er[1]}, '0);
    chk("mid_rst_nodone", done_cnt[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    build(0, 2, 32, 2'b00, 0);
    build(1, 5, 64, 2'b00, 0);
    run(2'b00, 0, 0, s);
    wait_end(0, 100);
    check_run(s, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
